lab3_cache_mem_responder: RTL
=============================

# lab3_cache_mem_responder

Test-memory responder for the cache's memory-side port. It accepts `mem_req_4B_t` requests (refill reads, evict/flush writebacks, inits) and returns `mem_resp_4B_t` responses in order after a programmable minimum latency. It has bounded outstanding-request buffering with val/rdy backpressure on both sides. It instantiates in the cache test harness between the cache datapath's memory request/response ports and nothing else.

## Interface
- `p_mem_nbytes`, 4096: memory size in bytes; power of two, ≥ 64.
- `p_latency`, 2: minimum cycles from request accept to response valid; range 1–15.
- `p_max_outstanding`, 4: response buffer depth; power of two, ≥ 1.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `memreq_val` in 1: request valid (driven by the cache's `cache_req_val`).
- `memreq_rdy` out 1: responder can accept a request.
- `memreq_msg` in `mem_req_4B_t`: type_, opaque, addr, len, data.
- `memresp_val` out 1: response valid.
- `memresp_rdy` in 1: consumer accepts the response.
- `memresp_msg` out `mem_resp_4B_t`: type_, opaque, test, len, data.

## Operation
- Storage is a word array of `p_mem_nbytes/4` words. Word index = `addr[log2(p_mem_nbytes)-1:2]`. Higher address bits are ignored, so addresses wrap. Contents are not cleared by reset.
- A request fires when `memreq_val && memreq_rdy` at a rising edge. The memory access executes at that edge, so all accesses occur in accept order.
- Byte count = len (0 means 4). Byte offset = `addr[1:0]`. Bytes beyond the word boundary are dropped.
- Read (type_ 0): response data = the selected bytes shifted to bit 0, zero-extended.
- Write (type_ 1) and init (type_ 2): the selected bytes are written from `data` low bytes upward, using byte enables. Response data = 0.
- Other type_ values: no memory change. The response is still produced, with data 0.
- Response fields: type_ echoes the request, opaque echoes, len echoes, test = 0.
- Response buffer: in-order FIFO of `p_max_outstanding` entries.
  - Each entry holds the response message plus a 4-bit countdown. On enqueue the countdown loads `p_latency-1`. Every entry's countdown decrements each cycle and saturates at 0.
  - `memresp_val` = FIFO non-empty and the head countdown equals 0.
- `memreq_rdy` = (occupancy < `p_max_outstanding`). It is computed from occupancy at the start of the cycle only, with no combinational path from `memresp_rdy`. When the FIFO is full, a same-cycle dequeue does not allow a same-cycle enqueue.
- Simultaneous enqueue and dequeue in one cycle leaves occupancy unchanged. Pointers wrap modulo depth.
- `memresp_msg` holds stable while `memresp_val && !memresp_rdy`.

## Timing
- Reset: `memresp_val`=0 and `memreq_rdy`=0 during the reset cycle. `memreq_rdy`=1 in the first cycle after reset deasserts. FIFO is empty, pointers are 0, `memresp_msg` is all-zero.
- Reset mid-operation discards all buffered responses. Writes already accepted remain committed in memory.
- Latency: a request accepted at the edge closing cycle N gives `memresp_val`=1 no earlier than cycle N+`p_latency`.
  - It is exactly N+`p_latency` if the FIFO head is free by then and the consumer is ready.
  - Stalls beyond that come only from `memresp_rdy` backpressure.
- Throughput: one request/cycle and one response/cycle sustained when `p_max_outstanding` ≥ `p_latency`+1.
- A full cache-line refill (16 reads, addr stepping by 4) with `memresp_rdy`=1 completes its last response at cycle 16+`p_latency`-1 after the first accept.

## Test plan
- Write then read:
  - write addr 0x0000_0840, len 0, data 0xDEADBEEF, opaque 0x12 -> write response with data 0, opaque 0x12, 2 cycles after accept.
  - read addr 0x840 -> data 0xDEADBEEF.
- Byte write: init word 0x100 = 0x11223344, then write len 1, addr 0x102, data 0xAA -> read 0x100 returns 0x11AA3344; read len 2 at addr 0x102 returns 0x000011AA.
- Backpressure, depth 4:
  - hold `memresp_rdy`=0 and issue 6 reads -> exactly 4 accepted and `memreq_rdy`=0.
  - raise `memresp_rdy` -> responses drain in order, `memreq_rdy` returns 1 the cycle after the first dequeue, and the remaining 2 requests are then accepted.
- Latency sweep: `p_latency`=1, 3, 15 with a single read -> `memresp_val` asserts exactly N+1, N+3, N+15.
- Wrap, `p_mem_nbytes`=4096: write 0x00001004 = 0x5A5A5A5A -> read 0x00000004 returns 0x5A5A5A5A.
- Reset mid-flight: accept 3 reads, assert reset for 1 cycle -> no responses emerge, `memreq_rdy`=1 the cycle after reset, and earlier written data is still readable.

Source files
------------

// File: rtl/lab3_cache_mem_responder_if.sv
// Message types and the val/rdy bundle between the cache's memory port
// and the test-memory responder.
package lab3_cache_mem_pkg;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

// Handshake: a message transfers at a rising edge where val && rdy. The sender
// holds msg stable while val is high and rdy is low; rdy never depends on val.
interface lab3_cache_mem_responder_if;
  import lab3_cache_mem_pkg::*;

  logic         memreq_val;
  logic         memreq_rdy;
  mem_req_4B_t  memreq_msg;
  logic         memresp_val;
  logic         memresp_rdy;
  mem_resp_4B_t memresp_msg;

  modport master (
    output memreq_val, memreq_msg, memresp_rdy,
    input  memreq_rdy, memresp_val, memresp_msg
  );

  modport slave (
    input  memreq_val, memreq_msg, memresp_rdy,
    output memreq_rdy, memresp_val, memresp_msg
  );
endinterface

// File: rtl/lab3_cache_mem_responder.sv
// Test memory for the cache's memory port: accesses execute at accept, responses
// leave an in-order buffer once their minimum-latency countdown reaches zero.
module lab3_cache_mem_responder
  import lab3_cache_mem_pkg::*;
#(
  parameter int p_mem_nbytes      = 4096,
  parameter int p_latency         = 2,
  parameter int p_max_outstanding = 4
) (
  input logic                        clk,
  input logic                        reset,
  lab3_cache_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(p_mem_nbytes);
  localparam int NW = p_mem_nbytes / 4;
  localparam int PW = (p_max_outstanding > 1) ? $clog2(p_max_outstanding) : 1;
  localparam int OW = $clog2(p_max_outstanding + 1);
  localparam logic [3:0]    LOAD = 4'(p_latency - 1);
  localparam logic [PW-1:0] LAST = PW'(p_max_outstanding - 1);
  localparam logic [OW-1:0] FULL = OW'(p_max_outstanding);

  logic [31:0]  mem [NW];
  mem_resp_4B_t buf_msg [p_max_outstanding];
  logic [3:0]   buf_cnt [p_max_outstanding];
  logic [PW-1:0] head, tail;
  logic [OW-1:0] occ;

  mem_req_4B_t  req;
  mem_resp_4B_t resp;
  logic [AW-3:0] idx;
  logic [1:0]   off;
  logic [2:0]   nbytes;
  logic [3:0]   lo, hi, ben;
  logic [31:0]  wdata, rword, shifted, rdata;
  logic         is_write, enq, deq;
  logic         unused_addr;

  assign req         = bus.memreq_msg;
  assign idx         = req.addr[AW-1:2];
  assign off         = req.addr[1:0];
  assign unused_addr = ^req.addr[31:AW];

  always_comb begin
    nbytes   = (req.len == 2'd0) ? 3'd4 : {1'b0, req.len};
    lo       = {2'b00, off};
    hi       = lo + {1'b0, nbytes};
    for (int b = 0; b < 4; b++) begin
      ben[b] = (4'(b) >= lo) && (4'(b) < hi);
    end
    wdata    = req.data << {off, 3'b000};
    rword    = mem[idx];
    shifted  = rword >> {off, 3'b000};
    case (nbytes)
      3'd1:    rdata = {24'b0, shifted[7:0]};
      3'd2:    rdata = {16'b0, shifted[15:0]};
      3'd3:    rdata = {8'b0,  shifted[23:0]};
      default: rdata = shifted;
    endcase
    is_write   = (req.type_ == 3'd1) || (req.type_ == 3'd2);
    resp       = '0;
    resp.type_ = req.type_;
    resp.opaque = req.opaque;
    resp.len   = req.len;
    resp.data  = (req.type_ == 3'd0) ? rdata : 32'b0;
  end

  // Ready looks only at start-of-cycle occupancy, so a full buffer refuses
  // a request even while its head is leaving.
  assign bus.memreq_rdy  = !reset && (occ < FULL);
  assign bus.memresp_val = !reset && (occ != '0) && (buf_cnt[head] == 4'd0);
  assign bus.memresp_msg = buf_msg[head];

  assign enq = bus.memreq_val && bus.memreq_rdy;
  assign deq = bus.memresp_val && bus.memresp_rdy;

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (enq && is_write) begin
      for (int b = 0; b < 4; b++) begin
        if (ben[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < p_max_outstanding; i++) begin
        buf_msg[i] <= '0;
        buf_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < p_max_outstanding; i++) begin
        if (enq && (tail == PW'(i))) begin
          buf_msg[i] <= resp;
          buf_cnt[i] <= LOAD;
        end else if (buf_cnt[i] != 4'd0) begin
          buf_cnt[i] <= buf_cnt[i] - 4'd1;
        end
      end
      if (enq) tail <= (tail == LAST) ? '0 : tail + PW'(1);
      if (deq) head <= (head == LAST) ? '0 : head + PW'(1);
      case ({enq, deq})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule
